// File: rtl/imem_line_buffer.sv
// imem_line_buffer: single-line instruction buffer between the fetch stage and a
// slow burst memory. It answers hits in the same cycle. On a miss it stalls fetch
// and burst-fills one LINE_WORDS-word line, then answers from that line.
//
// Optional feature: define IMEM_ALIGN_CHK_EN to flag misaligned fetch addresses
// on imem_misalign instead of serving them. With the macro undefined the buffer
// is word-addressed and imem_misalign is tied low.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   imem_addr      fetch byte address (PC)
//   imem_data      instruction word; valid when imem_stall is low
//   imem_stall     high while imem_data is not valid; fetch holds PC
//   flush          one-cycle pulse that invalidates the line
//   mem_req        burst request, held high until the last beat is accepted
//   mem_addr       line-aligned burst base address
//   mem_ack        one beat accepted this cycle, mem_rdata valid
//   mem_rdata      burst data, ascending word order
//   imem_misalign  misaligned fetch flag (IMEM_ALIGN_CHK_EN builds only)
module imem_line_buffer #(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    output logic        imem_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        imem_misalign
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = 2 + IDX_W;
    localparam int unsigned TAG_W = 32 - OFF_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [TAG_W-1:0] tag;
    logic             valid;
    logic             flush_pend;
    logic [IDX_W-1:0] beat;
    logic [31:0]      words [LINE_WORDS];

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] addr_idx;
    logic             hit;
    logic             misalign;
    logic             start_fill;
    logic             last_ack;

    assign addr_tag = imem_addr[31:OFF_W];
    assign addr_idx = imem_addr[OFF_W-1:2];
    assign hit      = valid && (state == IDLE) && (addr_tag == tag);

    // Misalignment is only meaningful while the buffer can answer (IDLE).
`ifdef IMEM_ALIGN_CHK_EN
    assign misalign = (state == IDLE) && (imem_addr[1:0] != 2'b00);
`else
    logic unused_byte_offset;
    assign unused_byte_offset = ^imem_addr[1:0];
    assign misalign = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the combinational fetch-side response.
    always_comb begin
        state_next    = state;
        start_fill    = 1'b0;
        last_ack      = 1'b0;
        imem_stall    = 1'b1;
        imem_data     = 32'h0000_0000;
        imem_misalign = misalign;
        case (state)
            IDLE: begin
                if (misalign) begin
                    imem_stall = 1'b0;
                end else if (hit) begin
                    imem_stall = 1'b0;
                    imem_data  = words[addr_idx];
                end else begin
                    start_fill = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (mem_ack && (beat == IDX_W'(LINE_WORDS - 1))) begin
                    last_ack   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line control: request, base address, beat counter, tag and validity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= 1'b0;
            flush_pend <= 1'b0;
            beat       <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_ADDR;
            tag        <= '0;
        end else begin
            if (start_fill) begin
                mem_req    <= 1'b1;
                mem_addr   <= {addr_tag, OFF_W'(0)};
                beat       <= '0;
                valid      <= 1'b0;
                flush_pend <= 1'b0;
            end else if ((state == IDLE) && flush) begin
                valid <= 1'b0;
            end
            if (state == FILL) begin
                // A flush mid-burst cannot abort it; remember it so the line
                // is not marked valid when the burst finishes.
                if (flush) begin
                    flush_pend <= 1'b1;
                end
                if (mem_ack) begin
                    beat <= beat + IDX_W'(1);
                end
                if (last_ack) begin
                    mem_req    <= 1'b0;
                    tag        <= mem_addr[31:OFF_W];
                    valid      <= !flush_pend && !flush;
                    flush_pend <= 1'b0;
                end
            end
        end
    end

    // Line storage; contents are qualified by valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_ack) begin
            words[beat] <= mem_rdata;
        end
    end

endmodule
